spi_bus_bridge: RTL and testbench
=================================

// Module: spi_bus_bridge
// PURPOSE
//  SPI mode-0 slave bridging an external host to the internal register/memory bus, read and write.
//  Successor to the write-only SPI input block, with these additions:
//   - command byte selecting read/write and address auto-increment;
//   - MISO read-back with a one-frame turnaround;
//   - parametrised widths;
//   - all logic in the system clock domain (SCK/CS/MOSI are oversampled, no SCK-clocked flops).
// PARAMETERS
//  ADDRESS_BUS_WIDTH  16  address frame length in bits, and width of the address port
//  DATA_BUS_WIDTH     16  data frame length in bits, and width of the data ports
//  SYNC_STAGES        2   synchronizer depth for cs/sck/mosi (>=2)
// PORTS
//  clk            in   1    system clock
//  rst            in   1    synchronous, active-high reset
//  cs             in   1    SPI chip select, active low, asynchronous to clk
//  sck            in   1    SPI clock, asynchronous; f_sck <= f_clk/8
//  mosi           in   1    SPI data in, MSB first
//  miso           out  1    SPI data out, MSB first
//  miso_oe        out  1    MISO output enable; 1 while synced cs is low and state!=WAIT_CS
//  address        out  AW   bus address for the current access
//  data           out  DW   write data
//  write_strobe   out  1    1-cycle pulse: data valid for write at address
//  read_strobe    out  1    1-cycle pulse: request a read of address
//  read_data      in   DW   read return data
//  read_valid     in   1    1-cycle pulse qualifying read_data
//  busy           out  1    1 while state!=IDLE
//  read_underrun  out  1    sticky; set when read data was not available in time; cleared by rst or CS falling
// BEHAVIOUR
//  Reset values: every output is 0, and state=WAIT_CS. Reset mid-transfer abandons the transfer.
//  Input sync and edges: cs, sck and mosi pass through SYNC_STAGES flops.
//   - rise/fall = synced sck edge, detected one cycle later.
//   - mosi is sampled on the synced sck rise.
//  Frame sequence: CMD (8 bits), ADDR (AW bits), then for reads TURN (DW bits), then DATA frames (DW bits each).
//   - The bit counter reloads at every frame boundary.
//  CMD byte:
//   - bit7 = 1 read / 0 write
//   - bit6 = 1 auto-increment
//   - bits5:0 must be 0; nonzero -> WAIT_CS
//  States:
//   - WAIT_CS: ignore traffic until synced cs=1, then go to IDLE.
//   - IDLE: on cs falling, go to CMD; clear the bit counter and read_underrun.
//   - CMD: after 8 bits, go to ADDR.
//   - ADDR: after the last bit, latch address. Write -> DATA_WR. Read -> pulse read_strobe and go to TURN.
//   - TURN: miso=0. A read_valid arriving during TURN is captured in a holding reg. At end of frame, go to DATA_RD.
//   - DATA_WR: on the last bit, data<={shift,mosi}, and write_strobe pulses the cycle after that sck rise.
//     If auto-increment, address increments the cycle after the strobe.
//   - DATA_RD: at frame start, load the shift reg from the holding reg.
//     - Empty holding reg -> load 0 and set read_underrun.
//     - miso = shift MSB; shift left on each fall.
//     - Same cycle as the load: if auto-increment, address+1 and pulse read_strobe (prefetch for next frame).
//     - Without auto-increment, read_strobe re-reads the same address.
//  cs rising in any active state -> IDLE within 1 cycle.
//   - A partial frame produces no strobes; address/data keep their last values.
//  Boundary rules:
//   - Address wraps modulo 2^AW (0xFFFF+1 -> 0x0000).
//   - read_valid with no outstanding request is ignored.
//   - read_valid in the same cycle as cs rising is dropped.
//   - At most one outstanding read at any time.
//  Strobe timing: write_strobe and read_strobe are never asserted in the same cycle.
//   - address/data are stable from a strobe until the next strobe.
// STRUCTURE
//  Shared header spi_defs.vh: CMD bit positions, state encodings (3-bit), and clogb2 from functions.vh.
//  Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detector.
//   - Instantiated once each for sck and cs; mosi uses the synchronizer only.
//  Top level holds the FSM, bit counter, shift regs, holding reg and address counter (~250 lines).
// TESTING
//  Reset: rst held 3 cycles -> all outputs 0. With cs low at reset release, no strobes until cs toggles high.
//  Write burst, AW=DW=16, f_clk=10*f_sck:
//   - stimulus: CMD 0x40, ADDR 0x1234, data 0xBEEF, 0x0001.
//   - response: two write_strobe pulses; (0x1234,0xBEEF) then (0x1235,0x0001).
//  Read burst:
//   - stimulus: CMD 0xC0, ADDR 0x0010; bus model returns 0xA5A5 then 0x5A5A with 3-cycle latency.
//   - response: TURN frame on MISO = 0x0000; next frames 0xA5A5, 0x5A5A; read_strobe for 0x0010, 0x0011, 0x0012.
//  Underrun: bus model never asserts read_valid -> MISO data frames are 0x0000 and read_underrun=1.
//   - read_underrun clears on the next cs falling.
//  Abort and wrap:
//   - cs high after 7 bits of a data frame -> no write_strobe; state IDLE.
//   - Write burst at ADDR 0xFFFF with two data frames -> second write goes to 0x0000.
//  Bad command: CMD 0x01 -> no strobes for the rest of the transfer; a clean transfer then succeeds.

Source files
------------

// File: rtl/spi_bus_bridge_pkg.sv
// Shared definitions for the SPI-to-bus bridge: FSM encoding, command byte layout
// and a width helper.
package spi_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_CS  = 3'd0,
    ST_IDLE     = 3'd1,
    ST_CMD      = 3'd2,
    ST_ADDR     = 3'd3,
    ST_TURN     = 3'd4,
    ST_DATA_WR  = 3'd5,
    ST_DATA_RD  = 3'd6
  } state_t;

  localparam int CMD_LEN     = 8;
  localparam int CMD_RD_BIT  = 7;
  localparam int CMD_INC_BIT = 6;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_bus_bridge_sync_edge.sv
// Multi-flop synchronizer for an asynchronous SPI pin with rise/fall detection
// against the previous synchronized level.
module spi_bus_bridge_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns CMD/ADDR/DATA frames into internal bus reads and
// writes; all logic runs on clk with SCK/CS/MOSI oversampled.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// WAIT_CS    | after reset or a bad command: ignore traffic until cs is high
// IDLE       | cs high, waiting for cs to fall
// CMD        | shifting in the 8-bit command byte
// ADDR       | shifting in the address frame
// TURN       | read turnaround frame, miso held 0, first read in flight
// DATA_WR    | shifting in write data frames
// DATA_RD    | shifting out read data frames, prefetching the next word
module spi_bus_bridge
  import spi_bus_bridge_pkg::*;
#(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cs,
  input  logic                         sck,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         miso_oe,
  output logic [ADDRESS_BUS_WIDTH-1:0] address,
  output logic [DATA_BUS_WIDTH-1:0]    data,
  output logic                         write_strobe,
  output logic                         read_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  input  logic                         read_valid,
  output logic                         busy,
  output logic                         read_underrun
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int DW = DATA_BUS_WIDTH;
  localparam int SW = max3(CMD_LEN, AW, DW);
  localparam int CW = $clog2(SW);

  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_LEN - 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  logic                   cs_rise, cs_fall, sck_rise, sck_fall;
  logic                   cs_lvl;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  spi_bus_bridge_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_bus_bridge_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk  (clk),
    .rst  (rst),
    .din  (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  state_t         state;
  logic [CW-1:0]  bit_cnt;
  logic [SW-1:0]  rx_shift;
  logic [SW-1:0]  rx_next;
  logic [DW-1:0]  tx_shift;
  logic [DW-1:0]  hold;
  logic           hold_valid;
  logic           rd_pend;
  logic           load_pend;
  logic           rd_mode;
  logic           inc_mode;
  logic           rst_done;
  logic           last_bit;
  logic           src_valid;
  logic [DW-1:0]  src_data;

  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign rx_next   = {rx_shift[SW-2:0], mosi_s};
  assign last_bit  = (bit_cnt == '0);
  // A read return landing in the very cycle of a frame load is used directly.
  assign src_valid = hold_valid | (rd_pend & read_valid);
  assign src_data  = hold_valid ? hold : read_data;

  assign miso    = (state == ST_DATA_RD) & tx_shift[DW-1];
  assign miso_oe = ~cs_lvl & (state != ST_WAIT_CS);
  assign busy    = rst_done & (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_q        <= '0;
      cs_lvl        <= 1'b0;
      state         <= ST_WAIT_CS;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      hold          <= '0;
      hold_valid    <= 1'b0;
      rd_pend       <= 1'b0;
      load_pend     <= 1'b0;
      rd_mode       <= 1'b0;
      inc_mode      <= 1'b0;
      rst_done      <= 1'b0;
      address       <= '0;
      data          <= '0;
      write_strobe  <= 1'b0;
      read_strobe   <= 1'b0;
      read_underrun <= 1'b0;
    end else begin
      mosi_q       <= {mosi_q[SYNC_STAGES-2:0], mosi};
      rst_done     <= 1'b1;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      if (cs_rise)      cs_lvl <= 1'b1;
      else if (cs_fall) cs_lvl <= 1'b0;

      if (write_strobe && inc_mode) address <= address + ADDR_ONE;

      if (cs_rise && state != ST_WAIT_CS && state != ST_IDLE) begin
        state      <= ST_IDLE;
        rd_pend    <= 1'b0;
        hold_valid <= 1'b0;
        load_pend  <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_CS: if (cs_lvl) state <= ST_IDLE;
          ST_IDLE: if (cs_fall) begin
            state         <= ST_CMD;
            bit_cnt       <= CMD_LAST;
            tx_shift      <= '0;
            read_underrun <= 1'b0;
          end
          ST_CMD: if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt - CNT_ONE;
            if (last_bit) begin
              if (rx_next[5:0] != 6'd0) begin
                state <= ST_WAIT_CS;
              end else begin
                rd_mode  <= rx_next[CMD_RD_BIT];
                inc_mode <= rx_next[CMD_INC_BIT];
                bit_cnt  <= ADDR_LAST;
                state    <= ST_ADDR;
              end
            end
          end
          ST_ADDR: if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt - CNT_ONE;
            if (last_bit) begin
              address <= rx_next[AW-1:0];
              bit_cnt <= DATA_LAST;
              if (rd_mode) begin
                read_strobe <= 1'b1;
                rd_pend     <= 1'b1;
                state       <= ST_TURN;
              end else begin
                state <= ST_DATA_WR;
              end
            end
          end
          ST_DATA_WR: if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt - CNT_ONE;
            if (last_bit) begin
              data         <= rx_next[DW-1:0];
              write_strobe <= 1'b1;
              bit_cnt      <= DATA_LAST;
            end
          end
          ST_TURN, ST_DATA_RD: begin
            if (rd_pend && read_valid) begin
              hold       <= read_data;
              hold_valid <= 1'b1;
              rd_pend    <= 1'b0;
            end
            if (sck_rise) begin
              bit_cnt <= bit_cnt - CNT_ONE;
              if (last_bit) begin
                bit_cnt   <= DATA_LAST;
                load_pend <= 1'b1;
                state     <= ST_DATA_RD;
              end
            end
            // The first fall after a frame boundary presents the next word's MSB.
            if (sck_fall && state == ST_DATA_RD) begin
              if (load_pend) begin
                load_pend  <= 1'b0;
                hold_valid <= 1'b0;
                tx_shift   <= src_valid ? src_data : '0;
                if (!src_valid) read_underrun <= 1'b1;
                if (!rd_pend || read_valid) begin
                  read_strobe <= 1'b1;
                  rd_pend     <= 1'b1;
                  if (inc_mode) address <= address + ADDR_ONE;
                end
              end else begin
                tx_shift <= {tx_shift[DW-2:0], 1'b0};
              end
            end
          end
          default: state <= ST_WAIT_CS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Scoreboard bench for spi_bus_bridge: a bit-banged SPI host, a 3-cycle bus model
// and a strobe monitor that pops expected bus accesses from a queue.
module tb_spi_bus_bridge;

  logic        clk = 1'b0;
  logic        rst, cs, sck, mosi;
  logic        miso, miso_oe, write_strobe, read_strobe, busy, read_underrun;
  logic [15:0] address, data;
  logic [15:0] read_data;
  logic        read_valid;

  always #5 clk = ~clk;

  spi_bus_bridge #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH   (16),
    .SYNC_STAGES      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .sck          (sck),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .address      (address),
    .data         (data),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .busy         (busy),
    .read_underrun(read_underrun)
  );

  typedef struct packed {
    logic        is_wr;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  bus_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic push(input logic is_wr, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    e.is_wr = is_wr;
    e.a     = a;
    e.d     = d;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] bus_mem(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5A5;
      16'h0011: return 16'h5A5A;
      default:  return a ^ 16'h0F0F;
    endcase
  endfunction

  // Strobe monitor
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (write_strobe || read_strobe)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe: got wr=%b rd=%b addr=%h data=%h, want none",
                   write_strobe, read_strobe, address, data);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", {write_strobe, read_strobe}, e.is_wr ? 2'b10 : 2'b01);
          check("strobe_addr", address, e.a);
          if (e.is_wr) check("strobe_data", data, e.d);
        end
      end
    end
  end

  // Bus model: one read at a time, data returned 3 cycles after read_strobe
  initial begin
    logic [15:0] ra;
    read_valid = 1'b0;
    read_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && read_strobe && bus_en) begin
        ra = address;
        repeat (2) @(negedge clk);
        read_data  = bus_mem(ra);
        read_valid = 1'b1;
        @(negedge clk);
        read_valid = 1'b0;
      end
    end
  end

  task automatic spi_bit(input logic b, output logic m);
    sck  = 1'b0;
    mosi = b;
    repeat (5) @(negedge clk);
    m   = miso;
    sck = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_frame(input int len, input logic [31:0] val, output logic [31:0] rx);
    logic m;
    rx = '0;
    for (int i = len - 1; i >= 0; i--) begin
      spi_bit(val[i], m);
      rx = {rx[30:0], m};
    end
  endtask

  task automatic start_xfer();
    cs = 1'b0;
    repeat (5) @(negedge clk);
    check("start_busy", busy, 1);
    check("start_miso_oe", miso_oe, 1);
    check("start_underrun_clr", read_underrun, 0);
  endtask

  task automatic end_xfer();
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
    repeat (10) @(negedge clk);
    check("end_busy", busy, 0);
    check("end_miso_oe", miso_oe, 0);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [15:0] addr,
                      input logic [15:0] w0, input logic [15:0] w1,
                      output logic [15:0] m_turn, output logic [15:0] m0,
                      output logic [15:0] m1);
    logic [31:0] rx;
    start_xfer();
    spi_frame(8, {24'h0, cmd}, rx);
    spi_frame(16, {16'h0, addr}, rx);
    m_turn = '0;
    if (cmd[7]) begin
      spi_frame(16, 32'h0, rx);
      m_turn = rx[15:0];
    end
    spi_frame(16, {16'h0, w0}, rx);
    m0 = rx[15:0];
    spi_frame(16, {16'h0, w1}, rx);
    m1 = rx[15:0];
    end_xfer();
  endtask

  initial begin
    #20_000_000;
    bad++;
    $display("FAIL watchdog: got timeout, want test completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] mt, m0, m1;
    logic [31:0] rx;
    rst = 1'b1; cs = 1'b0; sck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {miso, miso_oe, address, data, write_strobe, read_strobe, busy, read_underrun}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("wait_cs_busy", busy, 1);
    check("wait_cs_miso_oe", miso_oe, 0);
    // Traffic with cs already low at reset release must be ignored
    spi_frame(8, 32'h40, rx);
    spi_frame(16, 32'h0001, rx);
    spi_frame(16, 32'h0002, rx);
    repeat (5) @(negedge clk);
    cs = 1'b1;
    repeat (5) @(negedge clk);
    sck = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_after_cs_high", busy, 0);

    push(1'b1, 16'h1234, 16'hBEEF);
    push(1'b1, 16'h1235, 16'h0001);
    xfer(8'h40, 16'h1234, 16'hBEEF, 16'h0001, mt, m0, m1);

    push(1'b0, 16'h0010, 16'h0);
    push(1'b0, 16'h0011, 16'h0);
    push(1'b0, 16'h0012, 16'h0);
    xfer(8'hC0, 16'h0010, 16'h0, 16'h0, mt, m0, m1);
    check("rd_inc_turn", mt, 16'h0000);
    check("rd_inc_d0", m0, 16'hA5A5);
    check("rd_inc_d1", m1, 16'h5A5A);
    check("rd_inc_no_underrun", read_underrun, 0);

    push(1'b0, 16'h0011, 16'h0);
    push(1'b0, 16'h0011, 16'h0);
    push(1'b0, 16'h0011, 16'h0);
    xfer(8'h80, 16'h0011, 16'h0, 16'h0, mt, m0, m1);
    check("rd_noinc_d0", m0, 16'h5A5A);
    check("rd_noinc_d1", m1, 16'h5A5A);

    bus_en = 1'b0;
    push(1'b0, 16'h0020, 16'h0);
    xfer(8'h80, 16'h0020, 16'h0, 16'h0, mt, m0, m1);
    check("underrun_turn", mt, 16'h0000);
    check("underrun_d0", m0, 16'h0000);
    check("underrun_d1", m1, 16'h0000);
    check("underrun_flag", read_underrun, 1);
    bus_en = 1'b1;

    // Abort after 7 bits of a data frame; start_xfer also checks the underrun clear
    start_xfer();
    spi_frame(8, 32'h00, rx);
    spi_frame(16, 32'h0100, rx);
    spi_frame(7, 32'h7F, rx);
    end_xfer();

    push(1'b1, 16'hFFFF, 16'h1111);
    push(1'b1, 16'h0000, 16'h2222);
    xfer(8'h40, 16'hFFFF, 16'h1111, 16'h2222, mt, m0, m1);

    xfer(8'h01, 16'h0033, 16'h4444, 16'h5555, mt, m0, m1);

    push(1'b1, 16'h0042, 16'h00C3);
    push(1'b1, 16'h0042, 16'h003C);
    xfer(8'h00, 16'h0042, 16'h00C3, 16'h003C, mt, m0, m1);

    repeat (20) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
